alu_seq_bcd_disp: RTL and testbench

- Parametrised successor to the combinational 3-bit ALU-plus-display block.
- Accepts a WIDTH-bit operand pair and an opcode with a start/busy/done handshake; multiply is multi-cycle (shift-add).
- Converts the magnitude of each result to BCD sequentially (double dabble, one bit per cycle).
- Drives DIGITS active-low 7-segment digits plus a separate sign digit for the board display.

---
 rtl/alu_disp_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 29 ++
 rtl/alu_seq_bcd_disp.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq_bcd_disp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared definitions for the sequential ALU with BCD 7-segment display:
// opcode encodings, the control FSM state type and active-low segment
// patterns in {g,f,e,d,c,b,a} bit order.
package alu_disp_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CONV,
    ST_DONE
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes (10..15) show blank.
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Map one BCD nibble to its segment pattern.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no path can infer a latch.
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_seq_bcd_disp.sv
// Sequential ALU with start/busy/done handshake, shift-add multiply and a
// one-bit-per-cycle double-dabble BCD converter driving DIGITS active-low
// 7-segment digits plus a sign digit.
// Optional build macro LEAD_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shows).
module alu_seq_bcd_disp
  import alu_disp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    result,
  output logic                  neg,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic [6:0]            hex_sign
);

  localparam int RES_W = 2 * WIDTH;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(RES_W + 1);

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [7*DIGITS-1:0] HEX_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_0};
`else
  localparam logic [7*DIGITS-1:0] HEX_RST = {DIGITS{SEG_0}};
`endif

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [RES_W-1:0]   mcand_q, acc_q, mag_q, bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_pend_q;
  logic [RES_W-1:0]   result_q;
  logic               neg_q, done_q;
  logic [7*DIGITS-1:0] hex_q;
  logic [6:0]         sign_q;

  logic [RES_W-1:0]   mul_acc_d, mag_d;
  logic               neg_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [7*DIGITS-1:0] seg_flat, hex_d;

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Operation result magnitude and sign for the exiting EXEC cycle.
  always_comb begin
    mag_d     = '0;
    neg_d     = 1'b0;
    mul_acc_d = acc_q + (b_q[0] ? mcand_q : '0);
    case (op_q)
      OP_ADD: mag_d = RES_W'(a_q) + RES_W'(b_q);
      OP_SUB: begin
        if (a_q >= b_q) begin
          mag_d = RES_W'(a_q - b_q);
        end else begin
          mag_d = RES_W'(b_q - a_q);
          neg_d = 1'b1;
        end
      end
      OP_XOR:  mag_d = RES_W'(a_q ^ b_q);
      OP_SHL:  mag_d = RES_W'({a_q, 1'b0});
      OP_MUL:  mag_d = mul_acc_d;
      OP_AND:  mag_d = RES_W'(a_q & b_q);
      OP_OR:   mag_d = RES_W'(a_q | b_q);
      default: mag_d = '0;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit.
  always_comb begin
    logic       carry;
    logic [3:0] adj;
    bcd_d = '0;
    carry = bin_q[RES_W-1];
    for (int i = 0; i < DIGITS; i++) begin
      adj               = dd_adjust(bcd_q[4*i +: 4]);
      bcd_d[4*i +: 4]   = {adj[2:0], carry};
      carry             = adj[3];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decode u_seg (
      .bcd_i (bcd_d[4*g +: 4]),
      .seg_o (seg_flat[7*g +: 7])
    );
  end

  // Display pattern for the final BCD value, with optional leading-zero blanking.
  always_comb begin
    hex_d = seg_flat;
`ifdef LEAD_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (bcd_d[4*i +: 4] != 4'd0) lead = 1'b0;
        if (lead && i != 0) hex_d[7*i +: 7] = SEG_BLANK;
      end
    end
`endif
  end

  // Control FSM with datapath and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is reset, so a reset mid-operation leaves no stale partial result behind.
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      hex_q      <= HEX_RST;
      sign_q     <= SEG_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            mcand_q <= RES_W'(a);
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q   <= mul_acc_d;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          if (op_q != OP_MUL || cnt_q == CNT_W'(WIDTH - 1)) begin
            mag_q      <= mag_d;
            bin_q      <= mag_d;
            bcd_q      <= '0;
            neg_pend_q <= neg_d;
            cnt_q      <= '0;
            state_q    <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(RES_W - 1)) begin
            result_q <= mag_q;
            neg_q    <= neg_pend_q;
            hex_q    <= hex_d;
            sign_q   <= neg_pend_q ? SEG_MINUS : SEG_BLANK;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign neg      = neg_q;
  assign hex_out  = hex_q;
  assign hex_sign = sign_q;

endmodule

// File: tb/tb_alu_seq_bcd_disp.sv
// Self-checking bench for alu_seq_bcd_disp (WIDTH=4, DIGITS=3): directed
// cases, randomized operations against an arithmetic reference model,
// busy/restart behaviour and reset in the middle of a conversion.
module tb_alu_seq_bcd_disp;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 3;
  localparam int RES_W  = 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [2:0]            op;
  logic [WIDTH-1:0]      a, b;
  logic                  busy, done, neg;
  logic [RES_W-1:0]      result;
  logic [7*DIGITS-1:0]   hex_out;
  logic [6:0]            hex_sign;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq_bcd_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .neg      (neg),
    .hex_out  (hex_out),
    .hex_sign (hex_sign)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] model_hex(input int val);
    logic [7*DIGITS-1:0] h;
    int v;
    v = val;
    h = '0;
    for (int i = 0; i < DIGITS; i++) begin
      h[7*i +: 7] = seg_of(v % 10);
`ifdef LEAD_ZERO_BLANK_EN
      if (i > 0 && v == 0) h[7*i +: 7] = 7'b1111111;
`endif
      v = v / 10;
    end
    return h;
  endfunction

  function automatic logic [7*DIGITS-1:0] reset_hex();
    logic [7*DIGITS-1:0] h;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef LEAD_ZERO_BLANK_EN
      h[7*i +: 7] = (i == 0) ? 7'b1000000 : 7'b1111111;
`else
      h[7*i +: 7] = 7'b1000000;
`endif
    end
    return h;
  endfunction

  task automatic model_op(input int o, input int x, input int y,
                          output int r, output bit n);
    n = 1'b0;
    case (o)
      0: r = x + y;
      1: if (x >= y) r = x - y; else begin r = y - x; n = 1'b1; end
      2: r = x ^ y;
      3: r = x * 2;
      4: r = x * y;
      5: r = x & y;
      6: r = x | y;
      default: r = 0;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  // Drive one start pulse; returns #1 after the edge that samples it,
  // with operands scrambled so latching is exercised.
  task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  task automatic wait_done(output int cycles, output bit timeout);
    cycles  = 0;
    timeout = 1'b1;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || neg !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b result=%0d neg=%b, expected 0 0 0 0", busy, done, result, neg);
    end
    tests_run++;
    if (hex_out !== reset_hex() || hex_sign !== 7'b1111111) begin
      tests_failed++;
      $display("FAIL reset_disp: hex=%h sign=%b, expected hex=%h sign=1111111", hex_out, hex_sign, reset_hex());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction compared against the model.
  task automatic test_op(input string name, input logic [2:0] o,
                         input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int  exp_r, exp_lat, cycles;
    bit  exp_n, timeout;
    model_op(int'(o), int'(x), int'(y), exp_r, exp_n);
    exp_lat = (o == 3'b100) ? WIDTH + RES_W : 1 + RES_W;
    launch(o, x, y);
    wait_done(cycles, timeout);
    tests_run++;
    if (timeout || cycles != exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d (timeout=%0b), expected %0d", name, cycles, timeout, exp_lat);
    end
    tests_run++;
    if (result !== RES_W'(exp_r) || neg !== exp_n) begin
      tests_failed++;
      $display("FAIL %s result: got %0d neg=%b, expected %0d neg=%b", name, result, neg, exp_r, exp_n);
    end
    tests_run++;
    if (hex_out !== model_hex(exp_r) || hex_sign !== (exp_n ? 7'b0111111 : 7'b1111111)) begin
      tests_failed++;
      $display("FAIL %s display: got hex=%h sign=%b, expected hex=%h neg=%b", name, hex_out, hex_sign, model_hex(exp_r), exp_n);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_directed();
    test_op("add_9_8", 3'b000, 4'd9, 4'd8);
    tests_run++;
`ifdef LEAD_ZERO_BLANK_EN
    if (hex_out !== {7'b1111111, 7'b1111001, 7'b1111000}) begin
`else
    if (hex_out !== {7'b1000000, 7'b1111001, 7'b1111000}) begin
`endif
      tests_failed++;
      $display("FAIL add_9_8 digits: got %b", hex_out);
    end
    test_op("sub_3_5", 3'b001, 4'd3, 4'd5);
    tests_run++;
    if (hex_sign !== 7'b0111111 || hex_out[6:0] !== 7'b0100100) begin
      tests_failed++;
      $display("FAIL sub_3_5 sign: got sign=%b d0=%b, expected 0111111 0100100", hex_sign, hex_out[6:0]);
    end
    test_op("sub_5_5", 3'b001, 4'd5, 4'd5);
    test_op("mul_15_15", 3'b100, 4'd15, 4'd15);
    tests_run++;
    if (result !== 8'd225 || hex_out !== {7'b0100100, 7'b0100100, 7'b0010010}) begin
      tests_failed++;
      $display("FAIL mul_max digits: got result=%0d hex=%b, expected 225", result, hex_out);
    end
    test_op("shl_12", 3'b011, 4'd12, 4'd3);
    test_op("xor_10_6", 3'b010, 4'd10, 4'd6);
    test_op("rsvd", 3'b111, 4'd13, 4'd9);
    test_op("and_12_10", 3'b101, 4'd12, 4'd10);
    test_op("or_12_3", 3'b110, 4'd12, 4'd3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      test_op("random", 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
    end
  endtask

  // MUL 7*3 with start re-pulsed and operands changed while busy.
  task automatic test_busy_ignore();
    int  done_cnt, done_at;
    bit  busy_ok;
    done_cnt = 0;
    done_at  = -1;
    busy_ok  = 1'b1;
    launch(3'b100, 4'd7, 4'd3);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc <= WIDTH + RES_W && busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == 2) begin start = 1'b1; op = 3'b000; a = 4'd1; b = 4'd1; end
      if (cyc == 5) start = 1'b0;
    end
    tests_run++;
    if (done_cnt != 1 || done_at != WIDTH + RES_W) begin
      tests_failed++;
      $display("FAIL busy_single_done: pulses=%0d at=%0d, expected 1 at %0d", done_cnt, done_at, WIDTH + RES_W);
    end
    tests_run++;
    if (!busy_ok) begin
      tests_failed++;
      $display("FAIL busy_held: busy dropped during operation, expected high throughout");
    end
    tests_run++;
    if (result !== 8'd21 || neg !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_result: got %0d neg=%b, expected 21 neg=0", result, neg);
    end
  endtask

  // Reset asserted while MUL 13*11 is converting.
  task automatic test_reset_mid_conv();
    int  done_cnt;
    launch(3'b100, 4'd13, 4'd11);
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || neg !== 1'b0 ||
        hex_out !== reset_hex() || hex_sign !== 7'b1111111) begin
      tests_failed++;
      $display("FAIL midreset_values: busy=%b done=%b result=%0d neg=%b hex=%h sign=%b, expected reset values",
               busy, done, result, neg, hex_out, hex_sign);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: %0d cycles with done/busy, expected 0", done_cnt);
    end
    test_op("add_after_reset", 3'b000, 4'd1, 4'd1);
    tests_run++;
    if (result !== 8'd2) begin
      tests_failed++;
      $display("FAIL add_after_reset_value: got %0d, expected 2", result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid_conv();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
